rr_select_arbiter: RTL
======================

RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

Interface
REQ-001 Parameter: NUM_CH, 8, number of requesting channels; fixed at 8, matching the 8-input 64-bit data selector driven by this block.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: req  input  8  per-channel request; bit i means channel i has a 64-bit word to send.
REQ-005 Port: out_ready  input  1  downstream accepts the selected word this cycle.
REQ-006 Port: req_last  input  8  per-channel end-of-packet flag; present only when PACKET_LOCK_EN is defined.
REQ-007 Port: select  output  3  binary channel index for the data selector (0 = input1 ... 7 = input8); registered.
REQ-008 Port: grant  output  8  one-hot copy of select, qualified by sel_valid; registered.
REQ-009 Port: sel_valid  output  1  select/grant are valid and a word is on offer downstream; registered.

Function
REQ-010 The block shall implement a two-state FSM: IDLE (sel_valid=0, grant=0) and GRANT (sel_valid=1, grant one-hot at select).
REQ-011 The block shall keep a 3-bit priority pointer ptr holding the last-served channel; search order is ptr+1, ptr+2, ... ptr, wrapping modulo 8.
REQ-012 In IDLE with req != 0, the block shall register the first requesting channel in search order into select/grant and enter GRANT; latency is 1 cycle from req sampled to sel_valid=1.
REQ-013 In IDLE with req == 0, the block shall remain in IDLE with select holding its last value.
REQ-014 A transfer shall occur on any edge where sel_valid=1 and out_ready=1; on transfer ptr shall load select.
REQ-015 On transfer, the block shall re-arbitrate in the same cycle using the updated pointer (excluding nothing: the just-served channel has lowest priority); if any req is set, it shall stay in GRANT with the new select next cycle (back-to-back, no bubble); otherwise it shall go to IDLE.
REQ-016 While sel_valid=1 and out_ready=0, select and grant shall be held stable.
REQ-017 If the granted channel's req is 0 while sel_valid=1 and out_ready=0, the grant shall be withdrawn: IDLE next cycle, ptr unchanged, no transfer counted.
REQ-018 If out_ready=1 and the granted req is 0 on the same edge, a transfer shall be counted (REQ-014 takes precedence).
REQ-019 grant shall never have more than one bit set; grant = 0 whenever sel_valid = 0.
REQ-020 A single requester shall be granted repeatedly, one word per cycle while out_ready=1.

Reset
REQ-021 On a rising clk edge with rst_n=0: state=IDLE, sel_valid=0, grant=8'h00, select=3'd0, ptr=3'd7, so channel 0 has top priority after reset.
REQ-022 Reset asserted mid-GRANT shall abort the grant with no transfer counted, regardless of out_ready.
REQ-023 The first arbitration is permitted on the first edge after rst_n returns high.

Configuration
REQ-024 The macro PACKET_LOCK_EN shall control packet locking; it is undefined by default.
REQ-025 With PACKET_LOCK_EN defined, a transfer with req_last[select]=0 shall keep the same select/grant and leave ptr unchanged; a transfer with req_last[select]=1 shall update ptr and rotate per REQ-015.
REQ-026 With PACKET_LOCK_EN defined, REQ-017 withdrawal shall still apply.
REQ-027 Without PACKET_LOCK_EN, the req_last port shall not exist and every transfer shall rotate per REQ-015.

Verification
REQ-028 Reset, then req=8'hFF, out_ready=1 for 10 cycles -> select sequence 0,1,2,3,4,5,6,7,0,1 with sel_valid=1 from cycle 2.
REQ-029 req=8'b0010_0100, out_ready=0 for 5 cycles, then 1 -> select=2 held stable for 5 cycles, then select=5 with no bubble.
REQ-030 Only req[3]=1, out_ready=1 -> select=3 every cycle; drop req[3] -> sel_valid=0 one cycle later.
REQ-031 Granted channel 6 with out_ready=0, req[6] deasserted -> IDLE next cycle, ptr unchanged; req=8'h41 then -> select=6 (ptr still 5).
REQ-032 rst_n=0 for one edge mid-GRANT with out_ready=1 -> sel_valid=0, grant=0, select=0; next req=8'h81 -> select=0.
REQ-033 PACKET_LOCK_EN defined: req=8'h03, req_last[0] low for 3 transfers then high -> select=0 for 4 transfers, then 1.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving an 8:1 word selector; optional packet locking under `PACKET_LOCK_EN`.
// Registered select/grant, 1 cycle req->sel_valid; holds the grant while out_ready=0 and withdraws it if the granted req drops.
module rr_select_arbiter #(
  parameter int NUM_CH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req,
`ifdef PACKET_LOCK_EN
  input  logic [NUM_CH-1:0]         req_last,
`endif
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH)-1:0] select,
  output logic [NUM_CH-1:0]         grant,
  output logic                      sel_valid
);

  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  r_select;
  logic [NUM_CH-1:0] r_grant;
  logic              r_sel_valid;

  logic              w_any;
  logic              w_rotate;
  logic [SEL_W-1:0]  w_pick_idle;
  logic [SEL_W-1:0]  w_pick_xfer;

  // First requester after base, wrapping; base itself is checked last.
  function automatic logic [SEL_W-1:0] f_pick(input logic [SEL_W-1:0] base,
                                               input logic [NUM_CH-1:0] r);
    logic [SEL_W-1:0] idx;
    f_pick = base;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = base + SEL_W'(k);
      if (r[idx]) f_pick = idx;
    end
  endfunction

  assign w_any       = |req;
  assign w_pick_idle = f_pick(r_ptr, req);
  assign w_pick_xfer = f_pick(r_select, req);

`ifdef PACKET_LOCK_EN
  assign w_rotate = req_last[r_select];
`else
  assign w_rotate = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel_valid <= 1'b0;
      r_grant     <= '0;
      r_select    <= '0;
      r_ptr       <= '1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_GRANT;
            r_sel_valid <= 1'b1;
            r_select    <= w_pick_idle;
            r_grant     <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick_idle;
          end
        end
        S_GRANT: begin
          if (out_ready) begin
            // A locked packet keeps its grant until the last word transfers.
            if (w_rotate) begin
              r_ptr <= r_select;
              if (w_any) begin
                r_select <= w_pick_xfer;
                r_grant  <= {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick_xfer;
              end else begin
                r_state     <= S_IDLE;
                r_sel_valid <= 1'b0;
                r_grant     <= '0;
              end
            end
          end else if (!req[r_select]) begin
            r_state     <= S_IDLE;
            r_sel_valid <= 1'b0;
            r_grant     <= '0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sel_valid <= 1'b0;
          r_grant     <= '0;
        end
      endcase
    end
  end

  assign select    = r_select;
  assign grant     = r_grant;
  assign sel_valid = r_sel_valid;

endmodule
